// File: rtl/cpu_pkg.sv
// Shared CPU word-format definitions used by the fetch/decode path.
package cpu_pkg;

  localparam int WORD_SIZE = 19;
  localparam int OPCODE_W  = 5;
  localparam int ADDR_W    = 14;

  typedef logic [WORD_SIZE-1:0] instr_t;
  typedef logic [OPCODE_W-1:0]  opcode_t;
  typedef logic [ADDR_W-1:0]    addr_t;

endpackage

// File: rtl/ipr_fifo_mem.sv
// Register array backing the prefetch queue: one synchronous write port,
// one asynchronous read port.
module ipr_fifo_mem #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic [AW-1:0]    RADDR,
  output logic [WIDTH-1:0] RDATA
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (WE) mem[WADDR] <= WDATA;
  end

  assign RDATA = mem[RADDR];

endmodule

// File: rtl/inst_prefetch_register.sv
// DEPTH-entry instruction prefetch queue between fetch and decode.
// Define IPR_PARITY_EN to store a parity bit per entry and report PAR_ERR.
module inst_prefetch_register #(
  parameter int WORD_SIZE = cpu_pkg::WORD_SIZE,
  parameter int OPCODE_W  = cpu_pkg::OPCODE_W,
  parameter int ADDR_W    = cpu_pkg::ADDR_W,
  parameter int DEPTH     = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [WORD_SIZE-1:0]  INSTR,
`ifdef IPR_PARITY_EN
  input  logic                  INSTR_PAR,
  output logic                  PAR_ERR,
`endif
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [OPCODE_W-1:0]   OPCODE,
  output logic [ADDR_W-1:0]     ADDRESS,
  output logic [$clog2(DEPTH):0] COUNT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef IPR_PARITY_EN
  localparam int ENTRY_W = WORD_SIZE + 1;
`else
  localparam int ENTRY_W = WORD_SIZE;
`endif

  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count, count_next;
  logic                 in_ready_q;
  logic                 push, pop;
  logic [ENTRY_W-1:0]   wr_entry, rd_entry;
  logic [WORD_SIZE-1:0] held_word, head_word;

  assign OUT_VALID = (count != '0);
  assign push      = IN_VALID && in_ready_q;
  assign pop       = OUT_VALID && OUT_READY;

`ifdef IPR_PARITY_EN
  assign wr_entry = {INSTR_PAR, INSTR};
  assign PAR_ERR  = OUT_VALID && (^rd_entry);
`else
  assign wr_entry = INSTR;
`endif

  ipr_fifo_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .CLK   (CLK),
    .WE    (push && !FLUSH),
    .WADDR (wr_ptr),
    .WDATA (wr_entry),
    .RADDR (rd_ptr),
    .RDATA (rd_entry)
  );

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // IN_READY is a registered copy of "not full" so it never depends on OUT_READY.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b1;
    end else if (FLUSH) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      in_ready_q <= (count_next != CNT_W'(DEPTH));
    end
  end

  // Remember the last visible head so the fields hold once the queue drains.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)         held_word <= '0;
    else if (OUT_VALID) held_word <= rd_entry[WORD_SIZE-1:0];
  end

  assign head_word = OUT_VALID ? rd_entry[WORD_SIZE-1:0] : held_word;
  assign OPCODE    = head_word[WORD_SIZE-1 -: OPCODE_W];
  assign ADDRESS   = head_word[ADDR_W-1:0];
  assign IN_READY  = in_ready_q;
  assign COUNT     = count;

endmodule
